uartlite_rx_ctrl: RTL and testbench
===================================

UARTLITE_RX_CTRL -- requirements
Module: uartlite_rx_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO entries (power of two, 2..256).
REQ-002 SHALL have parameter DEFAULT_PRESCALE, default 54, reset value of the PRESCALE register.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports s_axis_tdata (input, 8, received byte), s_axis_tvalid (input, 1, byte valid) and s_axis_tready (output, 1, FIFO can accept).
REQ-006 SHALL have ports overrun_error_in, frame_error_in and rx_busy (input, 1 each), the receiver's one-cycle error pulses and busy level.
REQ-007 SHALL have port prescale, output, 32, receiver bit-timing configuration.
REQ-008 SHALL have ports reg_addr (input, 4, byte address), reg_rd (input, 1), reg_wr (input, 1) and reg_wdata (input, 32).
REQ-009 SHALL have ports reg_rdata (output, 32) and reg_ack (output, 1).
REQ-010 SHALL have port irq, output, 1, level interrupt.

Function
REQ-011 Register map SHALL be: 0x0 RXDATA (RO, pop), 0x4 PRESCALE (RW), 0x8 STAT (RO), 0xC CTRL (WO); other addresses read 0 and ignore writes.
REQ-012 s_axis_tready SHALL equal !full; a byte SHALL be pushed on the cycle where tvalid && tready.
REQ-013 A pushed byte SHALL be visible in STAT (bit0 set) on the next cycle.
REQ-014 Register access: reg_ack SHALL pulse exactly one cycle after any reg_rd or reg_wr cycle, and reg_rdata SHALL be valid with reg_ack and 0 otherwise.
REQ-015 reg_rd and reg_wr asserted in the same cycle: the write SHALL be performed and the read SHALL have no side effect.
REQ-016 RXDATA read, FIFO non-empty: SHALL return {24'b0, head byte} and pop the FIFO.
REQ-017 RXDATA read, FIFO empty: SHALL return 0 with no pop and no pointer change.
REQ-018 Push and pop in the same cycle SHALL both occur, with the count unchanged; push into a full FIFO SHALL be impossible (tready = 0).
REQ-019 Pointers SHALL wrap modulo FIFO_DEPTH; count width SHALL be $clog2(FIFO_DEPTH)+1.
REQ-020 STAT bits SHALL be: 0 rx_valid (!empty), 1 rx_full, 3 rx_busy, 4 irq_en, 5 overrun, 6 frame_err; all other bits 0.
REQ-021 overrun and frame_err SHALL be sticky: set on the corresponding *_in pulse and cleared by a STAT read.
REQ-022 If an error pulse and a STAT read occur in the same cycle, the read SHALL return the old value and the flag SHALL end set.
REQ-023 CTRL write bit1 SHALL flush the FIFO (count = 0) next cycle; a push on the same cycle SHALL be dropped.
REQ-024 CTRL write bit4 SHALL set or clear irq_en; other CTRL bits SHALL be ignored.
REQ-025 PRESCALE write SHALL update the prescale output on the next cycle, regardless of rx_busy.
REQ-026 irq SHALL be registered as irq_en & (rx_valid | overrun | frame_err).

Reset
REQ-027 On rst SHALL set: FIFO empty, s_axis_tready = 1, prescale = DEFAULT_PRESCALE, irq_en = 0, overrun = frame_err = 0, irq = 0, reg_ack = 0, reg_rdata = 0.
REQ-028 rst mid-access SHALL suppress the pending reg_ack, and FIFO contents SHALL be discarded.

Structure
REQ-029 Package uartlite_pkg SHALL hold register offsets, STAT/CTRL bit indices and DEFAULT_PRESCALE.
REQ-030 Storage SHALL be a sub-module uartlite_rx_fifo (synchronous FIFO, count/full/empty outputs), with the register/flag logic in uartlite_rx_ctrl.

Verification
REQ-031 Push 0xA5, 0x3C; read RXDATA twice, then a third time -> returns 0xA5, 0x3C, then 0; STAT bit0 = 0 after the second read.
REQ-032 Push 16 bytes -> tready = 0 and STAT = 0x02|0x01; a 17th tvalid is held until one RXDATA read, then accepted next cycle.
REQ-033 Pulse frame_error_in, then read STAT twice -> first read returns bit6 = 1, second read returns bit6 = 0; overrun case checked the same way with bit5.
REQ-034 Write CTRL = 0x10 with FIFO empty -> irq = 0; push 0x55 -> irq = 1 two cycles after the handshake; pop -> irq = 0.
REQ-035 Fill 5 bytes, write CTRL = 0x02 while pushing 0x77 -> count = 0, next RXDATA read returns 0.
REQ-036 Write PRESCALE = 0x1B3; reset mid-operation -> prescale = 54 and STAT = 0.

Source files
------------

// File: rtl/uartlite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uartlite_pkg
// Description : Register offsets, STAT/CTRL bit positions and reset defaults
//               shared by the UART-lite receive path.
// Revision    : 1.0 - initial release
// ============================================================================
package uartlite_pkg;

    localparam logic [3:0] c_addr_rxdata   = 4'h0;
    localparam logic [3:0] c_addr_prescale = 4'h4;
    localparam logic [3:0] c_addr_stat     = 4'h8;
    localparam logic [3:0] c_addr_ctrl     = 4'hC;

    localparam int c_stat_rx_valid  = 0;
    localparam int c_stat_rx_full   = 1;
    localparam int c_stat_rx_busy   = 3;
    localparam int c_stat_irq_en    = 4;
    localparam int c_stat_overrun   = 5;
    localparam int c_stat_frame_err = 6;

    localparam int c_ctrl_flush  = 1;
    localparam int c_ctrl_irq_en = 4;

    localparam logic [31:0] c_default_prescale = 32'd54;

endpackage : uartlite_pkg
`default_nettype wire

// File: rtl/uartlite_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uartlite_rx_fifo
// Description : Synchronous byte FIFO with count/full/empty and a flush that
//               takes priority over a concurrent push.
// Revision    : 1.0 - initial release
// ============================================================================
module uartlite_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    input  logic                     flush,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;
    localparam logic [c_cw-1:0] c_full_count = c_cw'(DEPTH);

    logic [7:0]      r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_cw-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full  = (r_count == c_full_count);
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    assign w_do_push = push && !full && !flush;
    assign w_do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cw'(1);
                2'b01:   r_count <= r_count - c_cw'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : uartlite_rx_fifo
`default_nettype wire

// File: rtl/uartlite_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uartlite_rx_ctrl
// Description : UART-lite receive controller: RX FIFO, sticky error flags,
//               prescale/control registers and level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module uartlite_rx_ctrl
    import uartlite_pkg::*;
#(
    parameter int          FIFO_DEPTH       = 16,
    parameter logic [31:0] DEFAULT_PRESCALE = c_default_prescale
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        overrun_error_in,
    input  logic        frame_error_in,
    input  logic        rx_busy,
    output logic [31:0] prescale,
    input  logic [3:0]  reg_addr,
    input  logic        reg_rd,
    input  logic        reg_wr,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    output logic        reg_ack,
    output logic        irq
);

    localparam int c_cw = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]     r_prescale;
    logic            r_irq_en;
    logic            r_overrun;
    logic            r_frame_err;
    logic            r_irq;
    logic            r_ack;
    logic [31:0]     r_rdata;

    logic [7:0]      w_head;
    logic [c_cw-1:0] w_count;
    logic            w_full;
    logic            w_empty;
    logic            w_rx_valid;
    logic            w_rd_only;
    logic            w_pop;
    logic            w_push;
    logic            w_flush;
    logic            w_stat_rd;
    logic [31:0]     w_stat;
    logic [31:0]     w_rd_mux;

    // A simultaneous write wins: the read still returns data but has no side effect.
    assign w_rd_only  = reg_rd && !reg_wr;
    assign w_rx_valid = (w_count != '0);
    assign w_pop      = w_rd_only && (reg_addr == c_addr_rxdata) && !w_empty;
    assign w_stat_rd  = w_rd_only && (reg_addr == c_addr_stat);
    assign w_flush    = reg_wr && (reg_addr == c_addr_ctrl) && reg_wdata[c_ctrl_flush];
    assign w_push     = s_axis_tvalid && !w_full;

    assign s_axis_tready = !w_full;
    assign prescale      = r_prescale;
    assign reg_rdata     = r_rdata;
    assign reg_ack       = r_ack;
    assign irq           = r_irq;

    uartlite_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (s_axis_tdata),
        .pop   (w_pop),
        .flush (w_flush),
        .dout  (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_comb begin
        w_stat                   = '0;
        w_stat[c_stat_rx_valid]  = w_rx_valid;
        w_stat[c_stat_rx_full]   = w_full;
        w_stat[c_stat_rx_busy]   = rx_busy;
        w_stat[c_stat_irq_en]    = r_irq_en;
        w_stat[c_stat_overrun]   = r_overrun;
        w_stat[c_stat_frame_err] = r_frame_err;
    end

    always_comb begin
        w_rd_mux = '0;
        case (reg_addr)
            c_addr_rxdata:   w_rd_mux = w_empty ? 32'd0 : {24'd0, w_head};
            c_addr_prescale: w_rd_mux = r_prescale;
            c_addr_stat:     w_rd_mux = w_stat;
            default:         w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack   <= reg_rd || reg_wr;
            r_rdata <= reg_rd ? w_rd_mux : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prescale <= DEFAULT_PRESCALE;
            r_irq_en   <= 1'b0;
        end else if (reg_wr) begin
            if (reg_addr == c_addr_prescale) begin
                r_prescale <= reg_wdata;
            end
            if (reg_addr == c_addr_ctrl) begin
                r_irq_en <= reg_wdata[c_ctrl_irq_en];
            end
        end
    end

    // A new error pulse outranks the clear-on-read so no event is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (overrun_error_in) begin
                r_overrun <= 1'b1;
            end else if (w_stat_rd) begin
                r_overrun <= 1'b0;
            end
            if (frame_error_in) begin
                r_frame_err <= 1'b1;
            end else if (w_stat_rd) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_irq_en && (w_rx_valid || r_overrun || r_frame_err);
        end
    end

endmodule : uartlite_rx_ctrl
`default_nettype wire

// File: tb/tb_uartlite_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uartlite_rx_ctrl
// Description : Directed self-checking bench for uartlite_rx_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uartlite_rx_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        overrun_error_in;
    logic        frame_error_in;
    logic        rx_busy;
    logic [31:0] prescale;
    logic [3:0]  reg_addr;
    logic        reg_rd;
    logic        reg_wr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        reg_ack;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] r_data;

    always #5 clk = ~clk;

    uartlite_rx_ctrl #(
        .FIFO_DEPTH       (16),
        .DEFAULT_PRESCALE (32'd54)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .overrun_error_in (overrun_error_in),
        .frame_error_in   (frame_error_in),
        .rx_busy          (rx_busy),
        .prescale         (prescale),
        .reg_addr         (reg_addr),
        .reg_rd           (reg_rd),
        .reg_wr           (reg_wr),
        .reg_wdata        (reg_wdata),
        .reg_rdata        (reg_rdata),
        .reg_ack          (reg_ack),
        .irq              (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_read(input logic [3:0] addr, output logic [31:0] data);
        reg_addr = addr;
        reg_rd   = 1'b1;
        tick();
        reg_rd   = 1'b0;
        check("rd_ack", {31'd0, reg_ack}, 32'd1);
        data = reg_rdata;
    endtask

    task automatic reg_write(input logic [3:0] addr, input logic [31:0] data);
        reg_addr  = addr;
        reg_wdata = data;
        reg_wr    = 1'b1;
        tick();
        reg_wr    = 1'b0;
        check("wr_ack", {31'd0, reg_ack}, 32'd1);
    endtask

    task automatic push(input logic [7:0] b);
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0;
        overrun_error_in = 1'b0; frame_error_in = 1'b0; rx_busy = 1'b0;
        reg_addr = '0; reg_rd = 1'b0; reg_wr = 1'b0; reg_wdata = '0;
        repeat (3) tick();
        check("rst_tready", {31'd0, s_axis_tready}, 32'd1);
        check("rst_prescale", prescale, 32'd54);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_ack", {31'd0, reg_ack}, 32'd0);
        check("rst_rdata", reg_rdata, 32'd0);
        rst = 1'b0;
        tick();

        // Basic push/pop ordering and empty read
        reg_read(4'h8, r_data); check("stat_idle", r_data, 32'h0);
        tick();
        check("ack_drops", {31'd0, reg_ack}, 32'd0);
        check("rdata_idle", reg_rdata, 32'd0);
        push(8'hA5);
        push(8'h3C);
        reg_read(4'h8, r_data); check("stat_two", r_data, 32'h01);
        reg_read(4'h0, r_data); check("rx_a5", r_data, 32'hA5);
        reg_read(4'h0, r_data); check("rx_3c", r_data, 32'h3C);
        reg_read(4'h8, r_data); check("stat_empty", r_data, 32'h0);
        reg_read(4'h0, r_data); check("rx_empty", r_data, 32'h0);

        // Fill to full, hold a 17th byte until one pop
        for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
        check("full_tready", {31'd0, s_axis_tready}, 32'd0);
        reg_read(4'h8, r_data); check("stat_full", r_data, 32'h03);
        s_axis_tdata = 8'hEE; s_axis_tvalid = 1'b1;
        tick();
        check("held_tready", {31'd0, s_axis_tready}, 32'd0);
        reg_read(4'h0, r_data); check("rx_first", r_data, 32'h10);
        check("tready_after_pop", {31'd0, s_axis_tready}, 32'd1);
        tick();
        s_axis_tvalid = 1'b0;
        check("refull_tready", {31'd0, s_axis_tready}, 32'd0);
        for (int i = 1; i < 16; i++) begin
            reg_read(4'h0, r_data); check("rx_drain", r_data, 32'h10 + 32'(i));
        end
        reg_read(4'h0, r_data); check("rx_17th", r_data, 32'hEE);
        reg_read(4'h0, r_data); check("rx_drained", r_data, 32'h0);

        // Sticky error flags, clear on read, pulse racing a read
        frame_error_in = 1'b1; tick(); frame_error_in = 1'b0;
        reg_read(4'h8, r_data); check("frame_set", r_data, 32'h40);
        reg_read(4'h8, r_data); check("frame_clr", r_data, 32'h00);
        overrun_error_in = 1'b1; tick(); overrun_error_in = 1'b0;
        reg_read(4'h8, r_data); check("ovr_set", r_data, 32'h20);
        reg_read(4'h8, r_data); check("ovr_clr", r_data, 32'h00);
        frame_error_in = 1'b1;
        reg_read(4'h8, r_data); check("race_old", r_data, 32'h00);
        frame_error_in = 1'b0;
        reg_read(4'h8, r_data); check("race_kept", r_data, 32'h40);
        reg_read(4'h8, r_data); check("race_clr", r_data, 32'h00);
        rx_busy = 1'b1;
        reg_read(4'h8, r_data); check("stat_busy", r_data, 32'h08);
        rx_busy = 1'b0;

        // Interrupt enable and level
        reg_write(4'hC, 32'h10);
        tick();
        check("irq_empty", {31'd0, irq}, 32'd0);
        push(8'h55);
        check("irq_lat1", {31'd0, irq}, 32'd0);
        tick();
        check("irq_on", {31'd0, irq}, 32'd1);
        reg_read(4'h8, r_data); check("stat_irqen", r_data, 32'h11);
        reg_read(4'h0, r_data); check("rx_55", r_data, 32'h55);
        tick();
        check("irq_off", {31'd0, irq}, 32'd0);
        reg_write(4'hC, 32'h0);

        // Flush with a concurrent push
        for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
        s_axis_tdata = 8'h77; s_axis_tvalid = 1'b1;
        reg_write(4'hC, 32'h02);
        s_axis_tvalid = 1'b0;
        reg_read(4'h8, r_data); check("flush_stat", r_data, 32'h0);
        reg_read(4'h0, r_data); check("flush_rx", r_data, 32'h0);

        // Simultaneous read and write: read has no side effect
        push(8'h99);
        reg_addr = 4'h0; reg_rd = 1'b1; reg_wr = 1'b1; reg_wdata = 32'hFFFF_FFFF;
        tick();
        reg_rd = 1'b0; reg_wr = 1'b0;
        check("rdwr_ack", {31'd0, reg_ack}, 32'd1);
        reg_read(4'h8, r_data); check("rdwr_nopop", r_data, 32'h01);
        reg_read(4'h0, r_data); check("rx_99", r_data, 32'h99);

        // Unmapped and write-only addresses
        reg_write(4'h1, 32'hDEAD_BEEF);
        reg_read(4'h1, r_data); check("unmapped", r_data, 32'h0);
        reg_read(4'hC, r_data); check("ctrl_wo", r_data, 32'h0);
        check("prescale_untouched", prescale, 32'd54);

        // Prescale write, then reset mid-access
        reg_write(4'h4, 32'h1B3);
        check("prescale_new", prescale, 32'h1B3);
        reg_read(4'h4, r_data); check("prescale_rd", r_data, 32'h1B3);
        push(8'h42);
        frame_error_in = 1'b1; tick(); frame_error_in = 1'b0;
        reg_write(4'hC, 32'h10);
        reg_addr = 4'h8; reg_rd = 1'b1; rst = 1'b1;
        tick();
        reg_rd = 1'b0;
        check("rst_ack_supp", {31'd0, reg_ack}, 32'd0);
        check("rst_rdata_mid", reg_rdata, 32'd0);
        rst = 1'b0;
        check("rst_prescale2", prescale, 32'd54);
        check("rst_irq2", {31'd0, irq}, 32'd0);
        check("rst_tready2", {31'd0, s_axis_tready}, 32'd1);
        reg_read(4'h8, r_data); check("rst_stat", r_data, 32'h0);
        reg_read(4'h0, r_data); check("rst_rx", r_data, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_uartlite_rx_ctrl
`default_nettype wire
